// File: rtl/program_counter.sv
// Loadable program counter register holding the current instruction address.
// It updates from the next-PC mux only when enabled and never computes addresses itself.
module program_counter #(
   parameter int              WIDTH       = 11,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] pc
);

   logic [WIDTH-1:0] r_pc;

   // Reset is asynchronous, so it overrides an enabled load on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_VALUE;
      end else if (enable) begin
         r_pc <= in;
      end
   end

   assign pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: stimulus queues the expected pc value,
// and a monitor samples pc 1ns after each rising clk edge or falling reset edge.
module tb_program_counter;

   localparam int WIDTH = 11;

   typedef struct {
      logic [WIDTH-1:0] value;
      string            name;
   } expT;

   logic             clk;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] pc;

   expT sbQueue[$];
   int  checks   = 0;
   int  failures = 0;

   program_counter #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(11'h000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .in    (in),
      .pc    (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input expT e);
      checks++;
      if (pc !== e.value) begin
         failures++;
         $display("[TB] FAIL %s: pc=%h expected=%h", e.name, pc, e.value);
      end else begin
         $display("[TB] ok   %s: pc=%h", e.name, pc);
      end
   endtask

   // Drives inputs on the falling edge and queues the pc expected after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic [WIDTH-1:0] inVal,
                                input logic [WIDTH-1:0] expVal, input string name);
      expT e;
      @(negedge clk);
      reset  = rst;
      enable = en;
      in     = inVal;
      e.value = expVal;
      e.name  = name;
      sbQueue.push_back(e);
   endtask

   task automatic pushExpect(input logic [WIDTH-1:0] expVal, input string name);
      expT e;
      e.value = expVal;
      e.name  = name;
      sbQueue.push_back(e);
   endtask

   initial begin : monitor
      expT e;
      forever begin
         @(posedge clk or negedge reset);
         #1;
         if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int waitCycles;
      reset  = 1'b1;
      enable = 1'b0;
      in     = '0;
      repeat (2) @(posedge clk);

      // Reset falls mid-cycle; pc must clear with no clock edge.
      @(negedge clk);
      #2;
      pushExpect(11'h000, "reset_fall");
      reset = 1'b0;

      repeat (3) applyStimulus(1'b0, 1'b1, 11'h001, 11'h000, "reset_hold");
      applyStimulus(1'b1, 1'b0, 11'h000, 11'h000, "release_idle");

      applyStimulus(1'b1, 1'b1, 11'b101, 11'h005, "load5");
      applyStimulus(1'b1, 1'b1, 11'b110, 11'h006, "load6");
      applyStimulus(1'b1, 1'b0, 11'h000, 11'h006, "hold_a");
      applyStimulus(1'b1, 1'b0, 11'h000, 11'h006, "hold_b");
      applyStimulus(1'b1, 1'b1, 11'b111, 11'h007, "load7");
      applyStimulus(1'b1, 1'b1, 11'b100, 11'h004, "load4");
      applyStimulus(1'b1, 1'b1, 11'h7FF, 11'h7FF, "load_max");
      applyStimulus(1'b1, 1'b1, 11'h000, 11'h000, "load_zero");
      applyStimulus(1'b1, 1'b1, 11'b111, 11'h007, "load7_again");
      applyStimulus(1'b1, 1'b1, 11'b111, 11'h007, "load7_same");

      // Mid-run asynchronous reset between edges, with a pending enabled load.
      @(negedge clk);
      enable = 1'b1;
      in     = 11'h3FF;
      #2;
      pushExpect(11'h000, "async_reset");
      reset = 1'b0;

      applyStimulus(1'b1, 1'b0, 11'h000, 11'h000, "release_no_stale");
      applyStimulus(1'b1, 1'b1, 11'b101, 11'h005, "load5_after_reset");

      // Reset asserted in the same timestep as an enabled rising edge.
      @(negedge clk);
      enable = 1'b1;
      in     = 11'h123;
      pushExpect(11'h000, "collision");
      @(posedge clk);
      reset = 1'b0;

      applyStimulus(1'b0, 1'b1, 11'h055, 11'h000, "collision_hold");
      applyStimulus(1'b1, 1'b1, 11'h2AA, 11'h2AA, "first_edge_load");

      waitCycles = 0;
      while (sbQueue.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      if (sbQueue.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: pending=%0d expected=0", sbQueue.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 11-bit program counter register for the CPU datapath.
- Holds the address of the current instruction.
- Loads a new address from the next-PC mux (`in`) when `enable` is high, and otherwise holds its value.
- Sits between the next-PC selection logic (branch/jump/increment computed externally) and instruction memory addressing.

Parameters:
- WIDTH, 11, bit width of `in` and `pc` (address space of 2048 instructions).
- RESET_VALUE, 0, value `pc` takes during reset; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset.
- reset  input  1  asynchronous, active-low reset; `pc` forced to RESET_VALUE while low.
- enable  input  1  load enable; when high at a rising clk edge, `pc` captures `in`.
- in  input  WIDTH  next program counter value from the next-PC logic.
- pc  output  WIDTH  current program counter value; registered output.

Behaviour:
- Single register of WIDTH bits; `pc` is driven directly from it, with no combinational path from `in` or `enable` to `pc`.
- Reset:
  - reset = 0 forces `pc` = RESET_VALUE immediately, without waiting for a clk edge.
  - `pc` stays at RESET_VALUE for as long as reset is low, regardless of clk, enable or in.
- Reset release:
  - reset rising to 1 does not itself change `pc`.
  - The first rising clk edge with reset = 1 is the first edge at which loading can occur.
- Normal operation, at each rising clk edge with reset = 1:
  - enable = 1: `pc` <= `in`, visible one cycle later (latency 1 clock).
  - enable = 0: `pc` holds its previous value; `in` is ignored, including `in` = 0.
- No internal increment, wrap or arithmetic; the block is a pure loadable register. Any value 0..2^WIDTH-1 is loaded verbatim (e.g. 11'h7FF loads as 11'h7FF).
- Back-to-back enables: consecutive enabled edges load each new `in` value in turn. If `in` is unchanged across enabled edges, `pc` is unchanged.
- Simultaneous reset low and enabled clk edge: reset wins and `pc` = RESET_VALUE.
- Reset asserted mid-operation: `pc` drops to RESET_VALUE asynchronously, the loaded value is discarded, and no stale value reappears after release.
- Power-up before any reset: `pc` is undefined. The system must apply reset before use.
- No X-propagation requirements beyond standard register behaviour.

Test Plan:
- Reset hold:
  - Stimulus: reset = 0, enable = 1, in = 11'h001 toggling for 3 cycles.
  - Response: `pc` = 0 throughout, and becomes 0 within the same timestep reset falls, with no clk edge needed.
- Load:
  - Stimulus: reset = 1; enable = 1, in = 11'b101 at an edge.
  - Response: `pc` = 5 after that edge. Then in = 11'b110 at the next enabled edge gives `pc` = 6.
- Hold:
  - Stimulus: `pc` = 6; enable = 0, in = 0 for 2 edges.
  - Response: `pc` stays 6. Then enable = 1, in = 11'b111 gives `pc` = 7 after one edge; enable = 1, in = 11'b100 gives `pc` = 4.
- Boundary values:
  - Stimulus: enable = 1, load in = 11'h7FF, then in = 11'h000.
  - Response: `pc` = 0x7FF, then 0x000. No wrap or carry effects.
- Async reset mid-run:
  - Stimulus: `pc` = 7; drive reset low between clock edges.
  - Response: `pc` = 0 immediately. Release reset with enable = 0: `pc` stays 0. Next enabled edge with in = 11'b101 gives `pc` = 5.
- Reset vs enable collision:
  - Stimulus: reset low coincident with a rising edge where enable = 1, in = 11'h123.
  - Response: `pc` = 0, not 0x123.
